// File: rtl/ub_pkg.sv
// Shared types, default parameters and the burst-fit check for the banked unified buffer.
package ub_pkg;

    typedef enum logic [0:0] {IDLE, DRAIN} ub_state_t;

    localparam int unsigned UB_DATA_W       = 32;
    localparam int unsigned UB_DEPTH        = 64;
    localparam int unsigned UB_NUM_CH       = 2;
    localparam int unsigned UB_WORDS_PER_CH = 2;
    localparam int unsigned UB_WRAP_EN      = 0;

    // True when a burst starting at ptr ends at or before the top of memory.
    function automatic logic ub_space_ok(input int unsigned ptr, input int unsigned burst,
                                         input int unsigned depth);
        return (ptr + burst) <= depth;
    endfunction

endpackage

// File: rtl/unified_buffer_banked_if.sv
// Store, host-preload, pointer and read-port signals of the unified buffer.
interface unified_buffer_banked_if
    import ub_pkg::*;
#(
    parameter int unsigned DATA_W = UB_DATA_W,
    parameter int unsigned ADDR_W = $clog2(UB_DEPTH),
    parameter int unsigned NUM_CH = UB_NUM_CH,
    parameter int unsigned BURST  = UB_NUM_CH * UB_WORDS_PER_CH
);
    logic [NUM_CH-1:0]       store_valid;
    logic [BURST*DATA_W-1:0] store_data;
    logic                    store_ready;
    logic                    host_wr_en;
    logic [ADDR_W-1:0]       host_wr_addr;
    logic [DATA_W-1:0]       host_wr_data;
    logic                    ptr_load;
    logic [ADDR_W-1:0]       ptr_base;
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic [ADDR_W-1:0]       wr_ptr;
    logic                    busy;
    logic                    overflow;

    modport master (
        output store_valid, store_data, host_wr_en, host_wr_addr, host_wr_data,
               ptr_load, ptr_base, rd_en, rd_addr,
        input  store_ready, rd_data, rd_valid, wr_ptr, busy, overflow
    );

    modport slave (
        input  store_valid, store_data, host_wr_en, host_wr_addr, host_wr_data,
               ptr_load, ptr_base, rd_en, rd_addr,
        output store_ready, rd_data, rd_valid, wr_ptr, busy, overflow
    );

endinterface

// File: rtl/ub_mem.sv
// Single-write, single-read buffer memory; read returns pre-write contents, cleared on reset.
module ub_mem
    import ub_pkg::*;
#(
    parameter int unsigned DATA_W = UB_DATA_W,
    parameter int unsigned DEPTH  = UB_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem_q[rd_addr];
            end
        end
    end

endmodule

// File: rtl/unified_buffer_banked.sv
// Gathers one burst from all accumulator channels and drains it word by word into ub_mem
// at an auto-incrementing pointer; host preload writes take priority over the drain.
module unified_buffer_banked
    import ub_pkg::*;
#(
    parameter int unsigned DATA_W       = UB_DATA_W,
    parameter int unsigned DEPTH        = UB_DEPTH,
    parameter int unsigned NUM_CH       = UB_NUM_CH,
    parameter int unsigned WORDS_PER_CH = UB_WORDS_PER_CH,
    parameter int unsigned WRAP_EN      = UB_WRAP_EN,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned BURST  = NUM_CH * WORDS_PER_CH,
    localparam int unsigned IDX_W  = (BURST > 1) ? $clog2(BURST) : 1
) (
    input logic                    clk,
    input logic                    reset,
    unified_buffer_banked_if.slave bus
);

    ub_state_t         state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] burst_q [BURST];
    logic              overflow_q;

    logic [ADDR_W-1:0] eff_ptr;
    logic              space_ok;
    logic              all_valid;
    logic              accept;
    logic              drain_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // A same-cycle pointer load is applied before the fit check and the accept.
    always_comb begin
        eff_ptr   = bus.ptr_load ? bus.ptr_base : wr_ptr_q;
        space_ok  = (WRAP_EN != 0) || ub_space_ok(32'(eff_ptr), BURST, DEPTH);
        all_valid = &bus.store_valid;
        accept    = (state_q == IDLE) && all_valid && space_ok;
        drain_we  = (state_q == DRAIN) && !bus.host_wr_en;
        mem_we    = bus.host_wr_en || drain_we;
        mem_waddr = bus.host_wr_en ? bus.host_wr_addr : wr_ptr_q;
        mem_wdata = bus.host_wr_en ? bus.host_wr_data : burst_q[idx_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            for (int unsigned w = 0; w < BURST; w++) begin
                burst_q[w] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.ptr_load) begin
                        wr_ptr_q   <= bus.ptr_base;
                        overflow_q <= 1'b0;
                    end
                    if (accept) begin
                        for (int unsigned w = 0; w < BURST; w++) begin
                            burst_q[w] <= bus.store_data[w*DATA_W +: DATA_W];
                        end
                        idx_q   <= '0;
                        state_q <= DRAIN;
                    end else if (all_valid) begin
                        // Only reachable in saturate mode with too little room left.
                        overflow_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_we) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        idx_q    <= idx_q + 1'b1;
                        if (idx_q == IDX_W'(BURST - 1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.store_ready = (state_q == IDLE) && space_ok;
    assign bus.wr_ptr      = wr_ptr_q;
    assign bus.busy        = (state_q == DRAIN);
    assign bus.overflow    = overflow_q;

    ub_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (mem_we),
        .wr_addr  (mem_waddr),
        .wr_data  (mem_wdata),
        .rd_en    (bus.rd_en),
        .rd_addr  (bus.rd_addr),
        .rd_data  (bus.rd_data),
        .rd_valid (bus.rd_valid)
    );

endmodule

// File: doc/unified_buffer_banked.md
# unified_buffer_banked

Parametrised on-chip activation/result buffer between the accumulator bank and the systolic-array input feeders. Gathers one result burst from `NUM_CH` accumulator channels, `WORDS_PER_CH` words each, once every channel flags valid. Drains the burst into memory one word per cycle at an auto-incrementing write pointer. Also provides a host preload port and a synchronous read port, replacing hard-coded activation initialisation.

## Interface
Parameters:
- `DATA_W`, 32, word width
- `DEPTH`, 64, memory words; must be a power of two
- `NUM_CH`, 2, accumulator channels
- `WORDS_PER_CH`, 2, words delivered per channel per burst
- `WRAP_EN`, 0, 1 = write pointer wraps modulo `DEPTH`; 0 = saturate (refuse bursts that do not fit)
- Derived: `ADDR_W = $clog2(DEPTH)`, `BURST = NUM_CH*WORDS_PER_CH`

Ports (reset `reset`, asynchronous, active-high; clock `clk`):
- `clk`  in  1  clock
- `reset`  in  1  async active-high reset
- `store_valid`  in  `NUM_CH`  per-channel full flag; held until accepted
- `store_data`  in  `BURST*DATA_W`  channel c word w at slice index c*WORDS_PER_CH+w
- `store_ready`  out  1  burst can be accepted this cycle
- `host_wr_en`  in  1  host preload write
- `host_wr_addr`  in  `ADDR_W`  preload address
- `host_wr_data`  in  `DATA_W`  preload data
- `ptr_load`  in  1  load write pointer from `ptr_base`; clears `overflow`
- `ptr_base`  in  `ADDR_W`  new write-pointer value
- `rd_en`  in  1  read request
- `rd_addr`  in  `ADDR_W`  read address
- `rd_data`  out  `DATA_W`  read data
- `rd_valid`  out  1  `rd_data` valid
- `wr_ptr`  out  `ADDR_W`  next drain address
- `busy`  out  1  drain in progress
- `overflow`  out  1  sticky: burst refused for lack of space (saturate mode)

## Operation
- States: IDLE, DRAIN.
- Acceptance:
  - In IDLE, `store_ready = 1` unless `WRAP_EN==0` and `wr_ptr + BURST > DEPTH`.
  - Accept when `&store_valid && store_ready`: capture `store_data` into the burst register, clear the word index, go to DRAIN.
  - Partial valid (some channels only) captures nothing.
- DRAIN:
  - Each cycle, write burst word[idx] to `mem[wr_ptr]`, then increment `wr_ptr` (modulo `DEPTH`) and `idx`.
  - After word `BURST-1` is written, return to IDLE.
  - `busy = (state==DRAIN)`.
- Host write collision: `host_wr_en` has priority over the drain write. The drain stalls that cycle; `idx` and `wr_ptr` hold. Host writes are allowed in any state.
- Read port:
  - `rd_en` gives `rd_data = mem[rd_addr]` and `rd_valid = 1` on the next cycle.
  - Same-cycle write to the same address returns the old data (read-before-write).
  - `rd_data` holds its last value when `rd_valid = 0`.
- `ptr_load`:
  - Honoured only when `busy = 0`; ignored while busy.
  - Sets `wr_ptr = ptr_base` and clears `overflow`.
  - Same cycle as an accept: the load applies first, and the burst drains from `ptr_base`.
- `overflow` sets when `&store_valid` in IDLE, `WRAP_EN==0`, and space is insufficient. It stays set until `ptr_load` or `reset`.
- Arithmetic: pointer math uses `ADDR_W+1` bits for the space check and `ADDR_W` bits (natural wrap) for addressing.

## Timing
- Reset values:
  - State IDLE; all memory words 0.
  - `wr_ptr = 0`, `store_ready = 1`, `busy = 0`, `overflow = 0`, `rd_data = 0`, `rd_valid = 0`.
- Reset asserted mid-drain abandons the burst; words already written are cleared by the reset.
- Accept at edge T: word i is written at edge T+1+i, with no host collisions. `store_ready` is low from T+1 to T+BURST.
- Minimum burst-to-burst spacing is `BURST+1` cycles.
- Each host collision extends the drain by 1 cycle.
- Read latency: 1 cycle.

## Structure
- Package `ub_pkg`:
  - state enum `ub_state_t` {IDLE, DRAIN};
  - default parameter constants;
  - a `ub_space_ok` function for the fit check.
- Sub-module `ub_mem`: `DEPTH`×`DATA_W` array with one write port (muxed host/drain), one synchronous read port (read-before-write), and async clear on `reset`.

## Test plan
- Defaults; both `store_valid` set with words 1,2,3,4 → mem[0..3] = 1,2,3,4 at edges T+1..T+4; `wr_ptr = 4`; `store_ready` low for 4 cycles.
- Only `store_valid[0]` held for 10 cycles → no writes, `wr_ptr = 0`; raising `store_valid[1]` then accepts.
- Host writes 0xAA to addr 2 during a drain cycle targeting addr 2 → drain stalls 1 cycle, final mem[2] = drain word, `busy` lasts 5 cycles.
- `WRAP_EN=0`, `ptr_load` base 62, burst → `store_ready = 0`, `overflow = 1`, memory unchanged. `ptr_load` base 60 → `overflow` clears and the burst writes 60..63.
- `WRAP_EN=1`, base 62, burst 5,6,7,8 → mem[62] = 5, mem[63] = 6, mem[0] = 7, mem[1] = 8, `wr_ptr = 2`.
- `rd_en` at addr 1 in the same cycle as the drain writes 9 there (old 0) → `rd_data = 0` next cycle; a re-read returns 9. Reset asserted mid-drain → all outputs at reset values, mem zero.
